// File: rtl/hamming74_defs_pkg.sv
// Shared Hamming(7,4) definitions: widths, FSM encodings, encoder and syndrome.
// Codewords are [0:6] vectors so that index k holds c_k.
package hamming74_defs;

  localparam int DATA_W = 4;
  localparam int CW_W   = 7;

  typedef logic [0:CW_W-1] cw_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic cw_t encode(input logic [DATA_W-1:0] d);
    cw_t c;
    c[0] = d[0] ^ d[2] ^ d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[3];
    c[3] = d[0] ^ d[1] ^ d[2];
    c[4] = d[2];
    c[5] = d[1];
    c[6] = d[0];
    return c;
  endfunction

  // Nonzero result is the 1-based position of a single flipped bit.
  function automatic logic [2:0] syndrome(input cw_t c);
    return {c[6] ^ c[5] ^ c[4] ^ c[3],
            c[6] ^ c[5] ^ c[2] ^ c[1],
            c[6] ^ c[4] ^ c[2] ^ c[0]};
  endfunction

endpackage

// File: rtl/hamming74_encode.sv
// Combinational 4->7 Hamming encoder with optional single-bit error injection.
// inject = k (1..7) flips codeword bit c[k-1]; 0 leaves the codeword clean.
module hamming74_encode
  import hamming74_defs::*;
(
  input  logic [DATA_W-1:0] i_din,
  input  logic [2:0]        i_inject_err,
  output cw_t               o_code
);

  cw_t w_mask;

  always_comb begin
    w_mask = '0;
    for (int k = 1; k <= CW_W; k++) begin
      w_mask[k-1] = (i_inject_err == 3'(k));
    end
  end

  assign o_code = encode(i_din) ^ w_mask;

endmodule

// File: rtl/hamming74_serial_tx.sv
// Hamming(7,4) serial transmitter: one-entry hold buffer in front of a 7-bit
// shift register, c0 first, each bit held CLKS_PER_BIT cycles; idle line is 1.
module hamming74_serial_tx
  import hamming74_defs::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  input  logic [2:0]        i_inject_err,
  output cw_t               o_code_par,
  output logic              o_tx_bit,
  output logic              o_tx_active,
  output logic              o_tx_first,
  output logic              o_tx_last,
  output logic              o_frame_done
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IDX_LAST = 3'(CW_W - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  cw_t                r_hold;
  logic               r_hold_valid;
  cw_t                r_shift;
  cw_t                r_code_par;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_idx;
  logic               r_din_ready;

  cw_t                w_code;
  logic               w_accept;
  logic               w_tc;
  logic               w_end;
  logic               w_load;
  logic               w_hold_valid_nxt;

  hamming74_encode u_encode (
    .i_din        (i_din),
    .i_inject_err (i_inject_err),
    .o_code       (w_code)
  );

  assign w_accept = i_din_valid & r_din_ready;
  assign w_tc     = (r_state == ST_SHIFT) && (r_cnt == CNT_TC);
  assign w_end    = w_tc && (r_idx == IDX_LAST);
  assign w_load   = r_hold_valid && ((r_state == ST_IDLE) || w_end);

  // Accept and load never coincide: accept needs an empty hold, load a full one.
  assign w_hold_valid_nxt = w_accept | (r_hold_valid & ~w_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_hold_valid)           w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_end && !r_hold_valid) w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_bit     = 1'b1;
    o_tx_active  = 1'b0;
    o_tx_first   = 1'b0;
    o_tx_last    = 1'b0;
    o_frame_done = 1'b0;
    if (r_state == ST_SHIFT) begin
      o_tx_bit     = r_shift[0];
      o_tx_active  = 1'b1;
      o_tx_first   = (r_idx == 3'd0);
      o_tx_last    = (r_idx == IDX_LAST);
      o_frame_done = w_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_din_ready  <= 1'b0;
      r_shift      <= '0;
      r_code_par   <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
    end else begin
      r_hold_valid <= w_hold_valid_nxt;
      r_din_ready  <= ~w_hold_valid_nxt;
      if (w_accept) begin
        r_hold <= w_code;
      end
      if (w_load) begin
        r_shift    <= r_hold;
        r_code_par <= r_hold;
        r_cnt      <= '0;
        r_idx      <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (w_tc) begin
          r_cnt   <= '0;
          r_shift <= {r_shift[1:CW_W-1], 1'b0};
          r_idx   <= w_end ? 3'd0 : r_idx + 3'd1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_din_ready = r_din_ready;
  assign o_code_par  = r_code_par;

endmodule
